// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, RV32I opcodes,
// immediate/result selects and the opcode-class decoder used by the FSM.
package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC   = 4'd3,
      S_MEM_RD = 4'd4,
      S_MEM_WR = 4'd5,
      S_WB     = 4'd6,
      S_BRANCH = 4'd7,
      S_JUMP   = 4'd8,
      S_FAULT  = 4'd9
   } state_e;

   typedef enum logic [6:0] {
      OP_R      = 7'b0110011,
      OP_I      = 7'b0010011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_BRANCH = 7'b1100011,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111
   } opcode_e;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_src_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'd0,
      RES_MEM = 2'd1,
      RES_PC4 = 2'd2
   } result_src_e;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JAL,
      CLS_JALR,
      CLS_ILLEGAL
   } op_class_e;

   function automatic op_class_e decode_class(input logic [6:0] op);
      op_class_e cls;
      case (op)
         OP_R, OP_I, OP_LUI, OP_AUIPC: cls = CLS_ALU;
         OP_LOAD:                      cls = CLS_LOAD;
         OP_STORE:                     cls = CLS_STORE;
         OP_BRANCH:                    cls = CLS_BRANCH;
         OP_JAL:                       cls = CLS_JAL;
         OP_JALR:                      cls = CLS_JALR;
         default:                      cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

   // Immediate format needed by EXEC for address/operand generation.
   function automatic imm_src_e exec_imm(input logic [6:0] op);
      imm_src_e imm;
      case (op)
         OP_STORE:         imm = IMM_S;
         OP_LUI, OP_AUIPC: imm = IMM_U;
         default:          imm = IMM_I;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/multicycle_controller_wait_timer.sv
// Memory wait counter: counts stalled cycles of one access and flags the
// cycle on which one more stall would reach LIMIT.
module mem_wait_timer #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   logic [7:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_count <= 8'd0;
      else if (i_clear)
         r_count <= 8'd0;
      else if (i_enable && (r_count != 8'hFF))
         r_count <= r_count + 8'd1;
   end

   // Only raised on a stalled cycle, so a ready on the limit cycle always wins.
   assign o_expired = i_enable && (r_count >= 8'(LIMIT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/write-back,
// counts retired instructions and traps on illegal opcodes or memory timeouts.
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [6:0]  opcode_i,
   input  logic        mem_ready_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic        ir_write_o,
   output logic        pc_write_o,
   output logic        branch_o,
   output logic        reg_write_o,
   output logic [2:0]  imm_src_o,
   output logic [1:0]  result_src_o,
   output logic        retire_o,
   output logic [31:0] instret_o,
   output logic        fault_o,
   output logic [3:0]  state_o
);

   state_e      r_state;
   op_class_e   r_cls;
   imm_src_e    r_imm_src;
   result_src_e r_result_src;
   logic        r_mem_req;
   logic        r_mem_we;
   logic        r_pc_write;
   logic        r_branch;
   logic        r_reg_write;
   logic        r_retire;
   logic        r_fault;
   logic [31:0] r_instret;

   logic        w_in_mem;
   logic        w_fetch_done;
   logic        w_retire;
   logic        w_expired;
   op_class_e   w_dec_cls;
   imm_src_e    w_exec_imm;

   assign w_in_mem     = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
   assign w_fetch_done = (r_state == S_FETCH) && mem_ready_i;
   assign w_retire     = r_retire || ((r_state == S_MEM_WR) && mem_ready_i);
   assign w_dec_cls    = decode_class(opcode_i);
   assign w_exec_imm   = exec_imm(opcode_i);

   mem_wait_timer #(
      .LIMIT(MEM_TIMEOUT)
   ) u_wait (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (!w_in_mem || mem_ready_i),
      .i_enable (w_in_mem && !mem_ready_i),
      .o_expired(w_expired)
   );

   // Registered outputs are loaded together with the state they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cls        <= CLS_ALU;
         r_imm_src    <= IMM_I;
         r_result_src <= RES_ALU;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_pc_write   <= 1'b0;
         r_branch     <= 1'b0;
         r_reg_write  <= 1'b0;
         r_retire     <= 1'b0;
         r_fault      <= 1'b0;
         r_instret    <= 32'd0;
      end else begin
         r_pc_write  <= 1'b0;
         r_branch    <= 1'b0;
         r_reg_write <= 1'b0;
         r_retire    <= 1'b0;
         r_imm_src   <= IMM_I;
         if (w_retire)
            r_instret <= r_instret + 32'd1;

         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_state   <= S_FETCH;
                  r_mem_req <= 1'b1;
               end
            end
            S_FETCH: begin
               if (mem_ready_i) begin
                  r_state   <= S_DECODE;
                  r_mem_req <= 1'b0;
               end else if (w_expired) begin
                  r_state   <= S_FAULT;
                  r_mem_req <= 1'b0;
                  r_fault   <= 1'b1;
               end
            end
            S_DECODE: begin
               r_cls <= w_dec_cls;
               case (w_dec_cls)
                  CLS_ALU, CLS_LOAD, CLS_STORE: begin
                     r_state   <= S_EXEC;
                     r_imm_src <= w_exec_imm;
                  end
                  CLS_BRANCH: begin
                     r_state   <= S_BRANCH;
                     r_branch  <= 1'b1;
                     r_imm_src <= IMM_B;
                     r_retire  <= 1'b1;
                  end
                  CLS_JAL, CLS_JALR: begin
                     r_state      <= S_JUMP;
                     r_pc_write   <= 1'b1;
                     r_reg_write  <= 1'b1;
                     r_result_src <= RES_PC4;
                     r_imm_src    <= (w_dec_cls == CLS_JAL) ? IMM_J : IMM_I;
                     r_retire     <= 1'b1;
                  end
                  default: begin
                     r_state <= S_FAULT;
                     r_fault <= 1'b1;
                  end
               endcase
            end
            S_EXEC: begin
               case (r_cls)
                  CLS_LOAD: begin
                     r_state      <= S_MEM_RD;
                     r_mem_req    <= 1'b1;
                     r_result_src <= RES_MEM;
                  end
                  CLS_STORE: begin
                     r_state   <= S_MEM_WR;
                     r_mem_req <= 1'b1;
                     r_mem_we  <= 1'b1;
                  end
                  default: begin
                     r_state      <= S_WB;
                     r_reg_write  <= 1'b1;
                     r_result_src <= RES_ALU;
                     r_retire     <= 1'b1;
                  end
               endcase
            end
            S_MEM_RD: begin
               if (mem_ready_i) begin
                  r_state     <= S_WB;
                  r_mem_req   <= 1'b0;
                  r_reg_write <= 1'b1;
                  r_retire    <= 1'b1;
               end else if (w_expired) begin
                  r_state      <= S_FAULT;
                  r_mem_req    <= 1'b0;
                  r_result_src <= RES_ALU;
                  r_fault      <= 1'b1;
               end
            end
            S_MEM_WR: begin
               // Request stays up: the next instruction fetch follows directly.
               if (mem_ready_i) begin
                  r_state  <= S_FETCH;
                  r_mem_we <= 1'b0;
               end else if (w_expired) begin
                  r_state   <= S_FAULT;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_fault   <= 1'b1;
               end
            end
            S_WB, S_BRANCH, S_JUMP: begin
               r_state      <= S_FETCH;
               r_mem_req    <= 1'b1;
               r_result_src <= RES_ALU;
            end
            S_FAULT: begin
               r_state <= S_FAULT;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_req_o    = r_mem_req;
   assign mem_we_o     = r_mem_we;
   assign ir_write_o   = w_fetch_done;
   assign pc_write_o   = w_fetch_done || r_pc_write;
   assign branch_o     = r_branch;
   assign reg_write_o  = r_reg_write;
   assign imm_src_o    = r_imm_src;
   assign result_src_o = r_result_src;
   assign retire_o     = w_retire;
   assign instret_o    = r_instret;
   assign fault_o      = r_fault;
   assign state_o      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one task per scenario, hand-computed
// expectations, built with MEM_TIMEOUT=4 so the timeout boundary is reachable.
module tb_multicycle_controller;
   import multicycle_controller_pkg::*;

   localparam int unsigned TMO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_i = 1'b0;
   logic [6:0]  opcode_i = 7'd0;
   logic        mem_ready_i = 1'b0;
   logic        mem_req_o, mem_we_o, ir_write_o, pc_write_o, branch_o, reg_write_o;
   logic [2:0]  imm_src_o;
   logic [1:0]  result_src_o;
   logic        retire_o, fault_o;
   logic [31:0] instret_o;
   logic [3:0]  state_o;

   int n_vec = 0;
   int n_err = 0;
   int n_rw  = 0;

   multicycle_controller #(.MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .opcode_i(opcode_i),
      .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .branch_o(branch_o),
      .reg_write_o(reg_write_o), .imm_src_o(imm_src_o), .result_src_o(result_src_o),
      .retire_o(retire_o), .instret_o(instret_o), .fault_o(fault_o), .state_o(state_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (reg_write_o === 1'b1) n_rw++;

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start_i = 1'b0; mem_ready_i = 1'b0; opcode_i = 7'd0;
      #2;
      rst = 1'b0;
      tick();
   endtask

   // From IDLE: fetch with immediate ready, then sit in DECODE with op applied.
   task automatic go_decode(input logic [6:0] op);
      start_i = 1'b1; tick();
      start_i = 1'b0; mem_ready_i = 1'b1; tick();
      mem_ready_i = 1'b0; opcode_i = op; #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; start_i = 1'b1; mem_ready_i = 1'b1; #2;
      n_vec++;
      if ({state_o, mem_req_o, mem_we_o, ir_write_o, pc_write_o, branch_o, reg_write_o, retire_o} !== {S_IDLE, 7'b0}) begin
         n_err++; $display("FAIL reset_ctrl got %h want %h", {state_o, mem_req_o, mem_we_o, ir_write_o, pc_write_o, branch_o, reg_write_o, retire_o}, {S_IDLE, 7'b0});
      end
      n_vec++;
      if ({imm_src_o, result_src_o, fault_o, instret_o} !== 38'd0) begin
         n_err++; $display("FAIL reset_data got %h want 0", {imm_src_o, result_src_o, fault_o, instret_o});
      end
      start_i = 1'b0; mem_ready_i = 1'b0; rst = 1'b0;
      tick(); tick();
      n_vec++;
      if ({state_o, mem_req_o} !== {S_IDLE, 1'b0}) begin
         n_err++; $display("FAIL idle_hold got %h want %h", {state_o, mem_req_o}, {S_IDLE, 1'b0});
      end
   endtask

   task automatic test_addi();
      int rw0;
      do_reset();
      rw0 = n_rw;
      start_i = 1'b1; tick();
      start_i = 1'b0; mem_ready_i = 1'b0; #1;
      n_vec++;
      if ({state_o, mem_req_o, ir_write_o, pc_write_o} !== {S_FETCH, 3'b100}) begin
         n_err++; $display("FAIL addi_fetch_wait got %h want %h", {state_o, mem_req_o, ir_write_o, pc_write_o}, {S_FETCH, 3'b100});
      end
      mem_ready_i = 1'b1; #1;
      n_vec++;
      if ({ir_write_o, pc_write_o, retire_o} !== 3'b110) begin
         n_err++; $display("FAIL addi_fetch_done got %b want 110", {ir_write_o, pc_write_o, retire_o});
      end
      tick();
      mem_ready_i = 1'b0; opcode_i = OP_I; #1;
      n_vec++;
      if ({state_o, mem_req_o, ir_write_o} !== {S_DECODE, 2'b00}) begin
         n_err++; $display("FAIL addi_decode got %h want %h", {state_o, mem_req_o, ir_write_o}, {S_DECODE, 2'b00});
      end
      tick();
      n_vec++;
      if ({state_o, imm_src_o, reg_write_o} !== {S_EXEC, IMM_I, 1'b0}) begin
         n_err++; $display("FAIL addi_exec got %h want %h", {state_o, imm_src_o, reg_write_o}, {S_EXEC, IMM_I, 1'b0});
      end
      tick();
      n_vec++;
      if ({state_o, reg_write_o, retire_o, result_src_o} !== {S_WB, 2'b11, RES_ALU}) begin
         n_err++; $display("FAIL addi_wb got %h want %h", {state_o, reg_write_o, retire_o, result_src_o}, {S_WB, 2'b11, RES_ALU});
      end
      tick();
      n_vec++;
      if ({state_o, retire_o, instret_o} !== {S_FETCH, 1'b0, 32'd1}) begin
         n_err++; $display("FAIL addi_retired got %h want %h", {state_o, retire_o, instret_o}, {S_FETCH, 1'b0, 32'd1});
      end
      n_vec++;
      if (n_rw - rw0 !== 1) begin
         n_err++; $display("FAIL addi_rw_count got %0d want 1", n_rw - rw0);
      end
   endtask

   task automatic test_lw();
      int reqs;
      reqs = 0;
      do_reset();
      go_decode(OP_LOAD);
      tick();
      n_vec++;
      if ({state_o, imm_src_o, mem_req_o} !== {S_EXEC, IMM_I, 1'b0}) begin
         n_err++; $display("FAIL lw_exec got %h want %h", {state_o, imm_src_o, mem_req_o}, {S_EXEC, IMM_I, 1'b0});
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         mem_ready_i = 1'b0; #1;
         if (mem_req_o === 1'b1) reqs++;
         n_vec++;
         if ({state_o, retire_o, result_src_o} !== {S_MEM_RD, 1'b0, RES_MEM}) begin
            n_err++; $display("FAIL lw_memrd_wait%0d got %h want %h", i, {state_o, retire_o, result_src_o}, {S_MEM_RD, 1'b0, RES_MEM});
         end
         tick();
      end
      mem_ready_i = 1'b1; #1;
      if (mem_req_o === 1'b1) reqs++;
      tick();
      mem_ready_i = 1'b0; #1;
      n_vec++;
      if (reqs !== 4) begin
         n_err++; $display("FAIL lw_req_cycles got %0d want 4", reqs);
      end
      n_vec++;
      if ({state_o, mem_req_o, reg_write_o, retire_o, result_src_o} !== {S_WB, 3'b011, RES_MEM}) begin
         n_err++; $display("FAIL lw_wb got %h want %h", {state_o, mem_req_o, reg_write_o, retire_o, result_src_o}, {S_WB, 3'b011, RES_MEM});
      end
      tick();
      n_vec++;
      if ({state_o, instret_o, result_src_o} !== {S_FETCH, 32'd1, RES_ALU}) begin
         n_err++; $display("FAIL lw_after got %h want %h", {state_o, instret_o, result_src_o}, {S_FETCH, 32'd1, RES_ALU});
      end
   endtask

   task automatic test_sw();
      int rw0;
      do_reset();
      rw0 = n_rw;
      go_decode(OP_STORE);
      tick();
      n_vec++;
      if ({state_o, imm_src_o, mem_we_o} !== {S_EXEC, IMM_S, 1'b0}) begin
         n_err++; $display("FAIL sw_exec got %h want %h", {state_o, imm_src_o, mem_we_o}, {S_EXEC, IMM_S, 1'b0});
      end
      tick();
      n_vec++;
      if ({state_o, mem_req_o, mem_we_o, retire_o} !== {S_MEM_WR, 3'b110}) begin
         n_err++; $display("FAIL sw_memwr_wait got %h want %h", {state_o, mem_req_o, mem_we_o, retire_o}, {S_MEM_WR, 3'b110});
      end
      tick();
      mem_ready_i = 1'b1; #1;
      n_vec++;
      if ({state_o, mem_we_o, retire_o} !== {S_MEM_WR, 2'b11}) begin
         n_err++; $display("FAIL sw_memwr_done got %h want %h", {state_o, mem_we_o, retire_o}, {S_MEM_WR, 2'b11});
      end
      tick();
      mem_ready_i = 1'b0; #1;
      n_vec++;
      if ({state_o, mem_we_o, mem_req_o, instret_o} !== {S_FETCH, 2'b01, 32'd1}) begin
         n_err++; $display("FAIL sw_after got %h want %h", {state_o, mem_we_o, mem_req_o, instret_o}, {S_FETCH, 2'b01, 32'd1});
      end
      n_vec++;
      if (n_rw !== rw0) begin
         n_err++; $display("FAIL sw_no_regwrite got %0d want 0", n_rw - rw0);
      end
   endtask

   task automatic test_fault();
      do_reset();
      go_decode(7'b1111111);
      tick();
      n_vec++;
      if ({state_o, fault_o} !== {S_FAULT, 1'b1}) begin
         n_err++; $display("FAIL illegal_fault got %h want %h", {state_o, fault_o}, {S_FAULT, 1'b1});
      end
      start_i = 1'b1; mem_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_vec++;
         if ({state_o, fault_o, mem_req_o, ir_write_o, pc_write_o, reg_write_o, retire_o} !== {S_FAULT, 6'b100000}) begin
            n_err++; $display("FAIL fault_hold%0d got %h want %h", i, {state_o, fault_o, mem_req_o, ir_write_o, pc_write_o, reg_write_o, retire_o}, {S_FAULT, 6'b100000});
         end
      end
   endtask

   task automatic test_timeout();
      do_reset();
      start_i = 1'b1; tick();
      start_i = 1'b0; mem_ready_i = 1'b0;
      for (int i = 1; i <= 3; i++) tick();
      n_vec++;
      if ({state_o, mem_req_o, fault_o} !== {S_FETCH, 2'b10}) begin
         n_err++; $display("FAIL tmo_before got %h want %h", {state_o, mem_req_o, fault_o}, {S_FETCH, 2'b10});
      end
      tick();
      n_vec++;
      if ({state_o, mem_req_o, fault_o} !== {S_FAULT, 2'b01}) begin
         n_err++; $display("FAIL tmo_fault got %h want %h", {state_o, mem_req_o, fault_o}, {S_FAULT, 2'b01});
      end
      do_reset();
      start_i = 1'b1; tick();
      start_i = 1'b0;
      for (int i = 1; i <= 3; i++) tick();
      mem_ready_i = 1'b1; #1;
      tick();
      mem_ready_i = 1'b0; #1;
      n_vec++;
      if ({state_o, fault_o} !== {S_DECODE, 1'b0}) begin
         n_err++; $display("FAIL tmo_ready_wins got %h want %h", {state_o, fault_o}, {S_DECODE, 1'b0});
      end
   endtask

   task automatic test_jump();
      do_reset();
      start_i = 1'b1; tick();
      start_i = 1'b0; mem_ready_i = 1'b1; tick();
      opcode_i = OP_JAL; #1;
      n_vec++;
      if ({state_o, ir_write_o, mem_req_o} !== {S_DECODE, 2'b00}) begin
         n_err++; $display("FAIL jal_decode_ready_ignored got %h want %h", {state_o, ir_write_o, mem_req_o}, {S_DECODE, 2'b00});
      end
      tick();
      n_vec++;
      if ({state_o, pc_write_o, reg_write_o, result_src_o, imm_src_o, retire_o} !== {S_JUMP, 2'b11, RES_PC4, IMM_J, 1'b1}) begin
         n_err++; $display("FAIL jal_jump got %h want %h", {state_o, pc_write_o, reg_write_o, result_src_o, imm_src_o, retire_o}, {S_JUMP, 2'b11, RES_PC4, IMM_J, 1'b1});
      end
      tick();
      n_vec++;
      if ({state_o, instret_o, result_src_o, ir_write_o} !== {S_FETCH, 32'd1, RES_ALU, 1'b1}) begin
         n_err++; $display("FAIL jal_after got %h want %h", {state_o, instret_o, result_src_o, ir_write_o}, {S_FETCH, 32'd1, RES_ALU, 1'b1});
      end
      tick();
      mem_ready_i = 1'b0; opcode_i = OP_JALR; #1;
      tick();
      n_vec++;
      if ({state_o, imm_src_o, result_src_o, pc_write_o} !== {S_JUMP, IMM_I, RES_PC4, 1'b1}) begin
         n_err++; $display("FAIL jalr_jump got %h want %h", {state_o, imm_src_o, result_src_o, pc_write_o}, {S_JUMP, IMM_I, RES_PC4, 1'b1});
      end
      tick();
      n_vec++;
      if (instret_o !== 32'd2) begin
         n_err++; $display("FAIL jalr_instret got %0d want 2", instret_o);
      end
   endtask

   task automatic test_lui();
      do_reset();
      go_decode(OP_LUI);
      tick();
      n_vec++;
      if ({state_o, imm_src_o} !== {S_EXEC, IMM_U}) begin
         n_err++; $display("FAIL lui_exec got %h want %h", {state_o, imm_src_o}, {S_EXEC, IMM_U});
      end
      tick();
      n_vec++;
      if ({state_o, reg_write_o, result_src_o, imm_src_o} !== {S_WB, 1'b1, RES_ALU, IMM_I}) begin
         n_err++; $display("FAIL lui_wb got %h want %h", {state_o, reg_write_o, result_src_o, imm_src_o}, {S_WB, 1'b1, RES_ALU, IMM_I});
      end
   endtask

   task automatic test_branch_wrap();
      do_reset();
      go_decode(OP_BRANCH);
      force dut.r_instret = 32'hFFFF_FFFF;
      #1;
      release dut.r_instret;
      #1;
      n_vec++;
      if (instret_o !== 32'hFFFF_FFFF) begin
         n_err++; $display("FAIL beq_preload got %h want ffffffff", instret_o);
      end
      tick();
      n_vec++;
      if ({state_o, branch_o, imm_src_o, retire_o, pc_write_o, reg_write_o} !== {S_BRANCH, 1'b1, IMM_B, 3'b100}) begin
         n_err++; $display("FAIL beq_branch got %h want %h", {state_o, branch_o, imm_src_o, retire_o, pc_write_o, reg_write_o}, {S_BRANCH, 1'b1, IMM_B, 3'b100});
      end
      tick();
      n_vec++;
      if ({state_o, branch_o, instret_o} !== {S_FETCH, 1'b0, 32'd0}) begin
         n_err++; $display("FAIL beq_wrap got %h want %h", {state_o, branch_o, instret_o}, {S_FETCH, 1'b0, 32'd0});
      end
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if ({state_o, mem_req_o, retire_o} !== {S_IDLE, 2'b00}) begin
         n_err++; $display("FAIL async_rst_fetch got %h want %h", {state_o, mem_req_o, retire_o}, {S_IDLE, 2'b00});
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_addi();
      test_lw();
      test_sw();
      test_fault();
      test_timeout();
      test_jump();
      test_lui();
      test_branch_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum memory wait cycles per access, range 1..255.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-004 SHALL have port start_i  input  1  leave IDLE and begin fetching.
REQ-005 SHALL have port opcode_i  input  7  opcode from the instruction register; valid from DECODE onward.
REQ-006 SHALL have port mem_ready_i  input  1  memory completes the current access this cycle.
REQ-007 SHALL have port mem_req_o  output  1  memory access request.
REQ-008 SHALL have port mem_we_o  output  1  write qualifier for mem_req_o.
REQ-009 SHALL have port ir_write_o  output  1  load the instruction register.
REQ-010 SHALL have port pc_write_o  output  1  unconditional PC update.
REQ-011 SHALL have port branch_o  output  1  conditional PC update, gated externally by the ALU zero flag.
REQ-012 SHALL have port reg_write_o  output  1  register-file write enable.
REQ-013 SHALL have port imm_src_o  output  3  immediate format: I=0, S=1, B=2, U=3, J=4.
REQ-014 SHALL have port result_src_o  output  2  write-back mux: ALU=0, memory=1, PC+4=2.
REQ-015 SHALL have port retire_o  output  1  one-cycle pulse per completed instruction.
REQ-016 SHALL have port instret_o  output  32  retired-instruction count.
REQ-017 SHALL have port fault_o  output  1  sticky fault flag.
REQ-018 SHALL have port state_o  output  4  current state encoding, for debug.

Function
REQ-019 SHALL implement a Moore FSM with states IDLE, FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB, BRANCH, JUMP and FAULT; all outputs decode from the state only.
REQ-020 IDLE->FETCH when start_i=1; otherwise the FSM SHALL stay in IDLE.
REQ-021 In FETCH, MEM_RD and MEM_WR, mem_req_o=1 SHALL be held until mem_ready_i=1 is sampled; the FSM advances on that edge; mem_we_o=1 only in MEM_WR.
REQ-022 FETCH SHALL assert ir_write_o and pc_write_o in the cycle mem_ready_i=1 only, then go to DECODE.
REQ-023 DECODE SHALL branch on opcode_i as follows:
  - R/I/Load/Store/LUI/AUIPC -> EXEC
  - B -> BRANCH
  - JAL/JALR -> JUMP
  - any other opcode -> FAULT
REQ-024 EXEC SHALL drive imm_src_o for the opcode class, then go to:
  - MEM_RD for Load
  - MEM_WR for Store
  - WB otherwise
REQ-025 MEM_RD SHALL go to WB with result_src_o=1 latched for WB.
REQ-026 WB SHALL assert reg_write_o for one cycle and then go to FETCH; MEM_WR->FETCH directly.
REQ-027 BRANCH SHALL assert branch_o with imm_src_o=2 for one cycle and then go to FETCH.
REQ-028 JUMP SHALL assert pc_write_o and reg_write_o with result_src_o=2 for one cycle and then go to FETCH; imm_src_o=4 for JAL, 0 for JALR.
REQ-029 retire_o SHALL pulse on the final cycle of WB, MEM_WR, BRANCH and JUMP; instret_o increments on the same edge and wraps from 0xFFFFFFFF to 0.
REQ-030 A wait counter SHALL clear on entry to each memory state and increment each cycle with mem_ready_i=0; on reaching MEM_TIMEOUT the FSM goes to FAULT.
REQ-031 FAULT SHALL assert fault_o, force all enables to 0, and be exited only by rst; start_i is ignored.
REQ-032 If mem_ready_i=1 arrives on the same cycle the counter reaches MEM_TIMEOUT, ready SHALL win.
REQ-033 mem_ready_i outside memory states SHALL be ignored.

Reset
REQ-034 rst SHALL immediately force:
  - state to IDLE
  - instret_o, the wait counter and all enables to 0
  - imm_src_o, result_src_o and fault_o to 0
REQ-035 rst asserted mid-access SHALL drop mem_req_o asynchronously, with no retire_o pulse.

Structure
REQ-036 Opcode enum, state enum, imm_src and result_src encodings SHALL live in a shared package used by the decoder and this block.
REQ-037 The wait counter SHALL be a sub-module mem_wait_timer (clear, enable, expired).

Verification
REQ-038 ADDI: start_i, ready=1 on the first request -> states FETCH, DECODE, EXEC, WB, FETCH; one reg_write_o; instret_o=1.
REQ-039 LW with ready delayed 3 cycles in MEM_RD -> mem_req_o high for 4 cycles; result_src_o=1 in WB; retire after WB.
REQ-040 SW -> mem_we_o=1 only in MEM_WR; reg_write_o never asserted; retire_o in MEM_WR.
REQ-041 opcode 7'b1111111 in DECODE -> FAULT next cycle; fault_o=1 held through 10 cycles of start_i=1.
REQ-042 MEM_TIMEOUT=4, ready never asserted in FETCH -> FAULT after 4 wait cycles; ready on the 4th cycle instead -> DECODE.
REQ-043 Preload instret to 0xFFFFFFFF and retire one BEQ -> 0; assert rst mid-FETCH -> IDLE, mem_req_o=0 without a clock edge.
